// File: rtl/fpnew_pkg.sv
// Subset of the fpnew_pkg types used by the integer-to-float cast scheduler.
package fpnew_pkg;

  typedef enum logic [2:0] {
    RNE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011,
    RMM = 3'b100,
    ROD = 3'b101,
    DYN = 3'b111
  } roundmode_e;

  typedef enum logic [1:0] {
    INT8,
    INT16,
    INT32,
    INT64
  } int_format_e;

  typedef struct packed {
    logic NV;
    logic DZ;
    logic OF;
    logic UF;
    logic NX;
  } status_t;

endpackage

// File: rtl/fpnew_i2f_sched_if.sv
// Bundle between the scheduler and the shared cast unit (issue side and result side).
interface fpnew_i2f_sched_if #(
  parameter int unsigned SrcWidth = 64,
  parameter int unsigned DstWidth = 32,
  parameter int unsigned IdxWidth = 2
) ();
  import fpnew_pkg::*;

  // Both directions: a transfer happens on a cycle where valid && ready; the
  // source holds valid and payload stable until that cycle.
  logic                cast_valid_o;
  logic                cast_ready_i;
  logic [SrcWidth-1:0] cast_operand_o;
  roundmode_e          cast_rnd_mode_o;
  logic                cast_op_mod_o;
  int_format_e         cast_int_fmt_o;
  logic [IdxWidth-1:0] cast_tag_o;

  logic                cast_valid_i;
  logic                cast_ready_o;
  logic [DstWidth-1:0] cast_result_i;
  status_t             cast_status_i;
  logic [IdxWidth-1:0] cast_tag_i;

  logic                cast_flush_o;

  modport master (
    output cast_valid_o, cast_operand_o, cast_rnd_mode_o, cast_op_mod_o,
    output cast_int_fmt_o, cast_tag_o, cast_ready_o, cast_flush_o,
    input  cast_ready_i, cast_valid_i, cast_result_i, cast_status_i, cast_tag_i
  );

  modport slave (
    input  cast_valid_o, cast_operand_o, cast_rnd_mode_o, cast_op_mod_o,
    input  cast_int_fmt_o, cast_tag_o, cast_ready_o, cast_flush_o,
    output cast_ready_i, cast_valid_i, cast_result_i, cast_status_i, cast_tag_i
  );

endinterface

// File: rtl/fpnew_rr_lock_arb.sv
// Round-robin arbiter whose grant is frozen while an offered request waits for ready.
module fpnew_rr_lock_arb #(
  parameter int unsigned NumReq = 4,
  localparam int unsigned IdxWidth = $clog2(NumReq)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  input  logic [NumReq-1:0]   valid_i,
  input  logic                issue_i,
  input  logic                stall_i,
  output logic [IdxWidth-1:0] gnt_idx_o,
  output logic                gnt_valid_o,
  output logic                lock_o
);

  logic [IdxWidth-1:0] prio_q, prio_d;
  logic                lock_q, lock_d;
  logic [IdxWidth-1:0] lock_idx_q, lock_idx_d;
  logic [IdxWidth-1:0] free_idx;
  logic                found;

  // First valid requester at or after the pointer, wrapping modulo NumReq.
  always_comb begin
    free_idx = prio_q;
    found    = 1'b0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      int unsigned pos;
      pos = 32'(prio_q) + k;
      if (pos >= NumReq) pos = pos - NumReq;
      if (!found && valid_i[IdxWidth'(pos)]) begin
        found    = 1'b1;
        free_idx = IdxWidth'(pos);
      end
    end
  end

  assign gnt_idx_o   = lock_q ? lock_idx_q : free_idx;
  assign gnt_valid_o = valid_i[gnt_idx_o];
  assign lock_o      = lock_q;

  always_comb begin
    prio_d     = prio_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    if (flush_i) begin
      lock_d = 1'b0;
    end else if (issue_i) begin
      prio_d = (gnt_idx_o == IdxWidth'(NumReq - 1)) ? '0 : gnt_idx_o + IdxWidth'(1);
      lock_d = 1'b0;
    end else if (stall_i) begin
      lock_d     = 1'b1;
      lock_idx_d = gnt_idx_o;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      prio_q     <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      prio_q     <= prio_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
    end
  end

endmodule

// File: rtl/fpnew_i2f_sched.sv
// Shares one integer-to-float cast unit among NumReq requesters: arbitrates, tags,
// routes in-order results back by tag, caps in-flight ops and keeps sticky flags.
module fpnew_i2f_sched import fpnew_pkg::*; #(
  parameter int unsigned NumReq      = 4,
  parameter int unsigned SrcWidth    = 64,
  parameter int unsigned DstWidth    = 32,
  parameter int unsigned MaxInflight = 4
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             flush_i,
  input  logic [NumReq-1:0]                req_valid_i,
  output logic [NumReq-1:0]                req_ready_o,
  input  logic [NumReq-1:0][SrcWidth-1:0]  req_operand_i,
  input  roundmode_e [NumReq-1:0]          req_rnd_mode_i,
  input  logic [NumReq-1:0]                req_op_mod_i,
  input  int_format_e [NumReq-1:0]         req_int_fmt_i,
  output logic [NumReq-1:0]                rsp_valid_o,
  input  logic [NumReq-1:0]                rsp_ready_i,
  output logic [DstWidth-1:0]              rsp_result_o,
  output status_t                          rsp_status_o,
  output status_t [NumReq-1:0]             flags_o,
  input  logic [NumReq-1:0]                flags_clr_i,
  fpnew_i2f_sched_if.master                cast,
  output logic                             busy_o
);

  localparam int unsigned IdxWidth = $clog2(NumReq);
  localparam int unsigned CntWidth = $clog2(MaxInflight + 1);
  localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(MaxInflight);

  logic [CntWidth-1:0] cnt_q, cnt_d;
  status_t [NumReq-1:0] flags_q, flags_d;

  logic [IdxWidth-1:0] gnt_idx;
  logic gnt_valid, lock;
  logic allowed, issue_hs, stall, rsp_hs, tag_ok;

  fpnew_rr_lock_arb #(.NumReq(NumReq)) i_arb (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (flush_i),
    .valid_i     (req_valid_i),
    .issue_i     (issue_hs),
    .stall_i     (stall),
    .gnt_idx_o   (gnt_idx),
    .gnt_valid_o (gnt_valid),
    .lock_o      (lock)
  );

  // No credit bypass: a full counter blocks issue even if a result leaves this cycle.
  assign allowed  = (cnt_q < MaxCnt) && !flush_i;
  assign issue_hs = cast.cast_valid_o && cast.cast_ready_i;
  assign stall    = cast.cast_valid_o && !cast.cast_ready_i;

  assign cast.cast_valid_o    = allowed && gnt_valid;
  assign cast.cast_operand_o  = req_operand_i[gnt_idx];
  assign cast.cast_rnd_mode_o = req_rnd_mode_i[gnt_idx];
  assign cast.cast_op_mod_o   = req_op_mod_i[gnt_idx];
  assign cast.cast_int_fmt_o  = req_int_fmt_i[gnt_idx];
  assign cast.cast_tag_o      = gnt_idx;
  assign cast.cast_flush_o    = flush_i;

  always_comb begin
    req_ready_o = '0;
    if (issue_hs) req_ready_o[gnt_idx] = 1'b1;
  end

  assign tag_ok = 32'(cast.cast_tag_i) < NumReq;

  // A flush drains the cast unit: accept everything, hand nothing to requesters.
  always_comb begin
    rsp_valid_o       = '0;
    cast.cast_ready_o = 1'b1;
    if (!flush_i) begin
      cast.cast_ready_o = tag_ok && rsp_ready_i[cast.cast_tag_i];
      if (cast.cast_valid_i && tag_ok) rsp_valid_o[cast.cast_tag_i] = 1'b1;
    end
  end

  assign rsp_hs       = cast.cast_valid_i && cast.cast_ready_o && !flush_i;
  assign rsp_result_o = cast.cast_result_i;
  assign rsp_status_o = cast.cast_status_i;

  always_comb begin
    cnt_d = cnt_q;
    if (flush_i) begin
      cnt_d = '0;
    end else if (issue_hs && !rsp_hs) begin
      cnt_d = cnt_q + CntWidth'(1);
    end else if (!issue_hs && rsp_hs) begin
      cnt_d = cnt_q - CntWidth'(1);
    end
  end

  // Clear first, then OR in the arriving status, so a same-cycle pair keeps the new status.
  always_comb begin
    flags_d = flags_q;
    for (int i = 0; i < NumReq; i++) begin
      if (flags_clr_i[i]) flags_d[i] = '0;
      if (rsp_hs && cast.cast_tag_i == IdxWidth'(i)) begin
        flags_d[i] = status_t'(flags_d[i] | cast.cast_status_i);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      flags_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      flags_q <= flags_d;
    end
  end

  assign flags_o = flags_q;
  assign busy_o  = (cnt_q != '0) || lock;

`ifndef SYNTHESIS
  cnt_le_max: assert property (@(posedge clk_i) disable iff (!rst_ni) cnt_q <= MaxCnt);
  cnt_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(rsp_hs && !issue_hs && cnt_q == '0));
`endif

endmodule

// File: doc/fpnew_i2f_sched.md
# fpnew_i2f_sched

Scheduler that shares one integer-to-float cast unit (`fpnew_i2fcast`) among `NumReq` independent requesters, such as lanes or issue ports.
- Arbitrates requests round-robin with stable grants under backpressure.
- Tags each issued operation with its requester index and routes the in-order results back by tag.
- Caps the number of operations in flight.
- Accumulates per-requester sticky exception flags.

It sits between the requesters and the cast unit's input and output handshakes.

## Interface
Parameters:
- `NumReq`, 4: number of requesters, ≥2.
- `SrcWidth`, 64: integer operand width, matching the cast unit's `SRC_WIDTH`.
- `DstWidth`, 32: result width, matching the cast unit's `DST_WIDTH`.
- `MaxInflight`, 4: cap on operations in flight, ≥1. Set it to at least the cast unit's pipeline depth.
- `IdxWidth`, `$clog2(NumReq)`: localparam, tag width.

Ports:
- `clk_i` in 1: clock. One clock; reset is synchronous and active-low.
- `rst_ni` in 1: synchronous, active-low reset.
- `flush_i` in 1: drop all in-flight state.
- `req_valid_i` in `NumReq`, `req_ready_o` out `NumReq`: per-requester handshake.
- `req_operand_i` in `NumReq`×`SrcWidth`: per-requester integer operand.
- `req_rnd_mode_i` in `NumReq`×`roundmode_e`, `req_op_mod_i` in `NumReq`, `req_int_fmt_i` in `NumReq`×`int_format_e`: per-requester operation fields.
- `rsp_valid_o` out `NumReq`, `rsp_ready_i` in `NumReq`: per-requester result handshake.
- `rsp_result_o` out `DstWidth`, `rsp_status_o` out `status_t`: shared result bus, meaningful only where `rsp_valid_o` is set.
- `flags_o` out `NumReq`×`status_t`: sticky per-requester flags.
- `flags_clr_i` in `NumReq`: per-requester flag clear.
- `cast_valid_o` out 1, `cast_ready_i` in 1, `cast_operand_o`, `cast_rnd_mode_o`, `cast_op_mod_o`, `cast_int_fmt_o`, `cast_tag_o` out `IdxWidth`: to the cast unit's input side.
- `cast_valid_i` in 1, `cast_ready_o` out 1, `cast_result_i`, `cast_status_i`, `cast_tag_i` in `IdxWidth`: from the cast unit's output side.
- `cast_flush_o` out 1: equals `flush_i`.
- `busy_o` out 1: set when the in-flight count is nonzero or a grant is locked.

## Operation
State:
- Round-robin pointer `prio_q`.
- Lock flag `lock_q` and locked index `lock_idx_q`.
- In-flight counter `cnt_q`, range 0..`MaxInflight`.
- Flags `flags_q[NumReq]`.

Arbitration:
- Issue is allowed when `cnt_q < MaxInflight` and `flush_i` is low.
- When not locked, the grant goes to the first valid requester at or after `prio_q`, wrapping modulo `NumReq`.
- When locked, the grant is `lock_idx_q`.
- `cast_valid_o` = allowed AND the granted requester's valid. The cast fields and tag are muxed from the grant.
- `req_ready_o[g]` = `cast_ready_i` AND `cast_valid_o`; all other bits are 0.

Lock and pointer:
- Lock: when `cast_valid_o` is high and `cast_ready_i` is low, set `lock_q` and capture the grant. Requesters must hold valid and data until they see ready.
- On an issue handshake: `prio_q` becomes grant+1, wrapping from `NumReq-1` to 0, and `lock_q` clears.

Response routing:
- `rsp_valid_o[cast_tag_i]` = `cast_valid_i`; all other bits are 0.
- `cast_ready_o` = `rsp_ready_i[cast_tag_i]`.
- `rsp_result_o` and `rsp_status_o` pass `cast_result_i` and `cast_status_i` straight through.

Counter:
- +1 on an issue handshake, −1 on a response handshake, unchanged when both happen in the same cycle.
- Must never exceed `MaxInflight` or underflow. Add assertions for both.

Flags:
- On a response handshake for tag t: `flags_q[t] |= cast_status_i`.
- `flags_clr_i[i]` zeroes `flags_q[i]`. If a clear and a set for the same i occur in one cycle, the result is `cast_status_i`: clear is applied first, then the set.
- `flags_o` = `flags_q`.

Flush:
- On the flush cycle: no issue, all `rsp_valid_o` forced to 0, `cast_ready_o` = 1 so the cast unit drains.
- Next cycle: `cnt_q` = 0 and `lock_q` = 0. `prio_q` and `flags_q` are kept.

## Timing
- Arbitration and routing are purely combinational from registered state. The scheduler adds zero cycles of latency in either direction.
- All state updates on the rising edge of `clk_i`.
- Synchronous reset when `rst_ni` is 0: `prio_q` = 0, `lock_q` = 0, `lock_idx_q` = 0, `cnt_q` = 0, `flags_q` = 0.
- Output values under reset:
  - `busy_o` = 0 and `flags_o` = 0.
  - `cast_valid_o` follows the inputs, and is 0 when all `req_valid_i` = 0.
  - `rsp_valid_o` mirrors `cast_valid_i`, which the cast unit holds at 0 under reset.
- Reset mid-operation discards in-flight state. The cast unit must be reset or flushed together with the scheduler.
- At `cnt_q = MaxInflight` with a response handshake in the same cycle, issue stays blocked that cycle. There is no combinational credit bypass.

## Structure
- No new package. Use `fpnew_pkg` types: `roundmode_e`, `int_format_e`, `status_t`.
- One sub-module, `fpnew_rr_lock_arb`: round-robin pointer plus lock, with output ports `gnt_idx_o` and `gnt_valid_o`.
- Counter, flags, and routing stay in `fpnew_i2f_sched`.

## Test plan
- Requesters 0–3 all valid, `cast_ready_i` = 1, `MaxInflight` = 4 → grants in order 0,1,2,3,0; the counter reaches 4 and issue stalls until a response.
- Requesters 1 and 2 valid, `cast_ready_i` low for 3 cycles → grant is held on 1 throughout; requester 2 is issued on the first cycle after requester 1's handshake.
- Response with tag 2 and `rsp_ready_i[2]` = 0 for 2 cycles → `cast_ready_o` = 0 for both cycles and the other `rsp_valid_o` bits stay 0; then a single handshake occurs.
- Response with tag 1, status NX, in the same cycle as `flags_clr_i[1]` = 1 while `flags_q[1]` = NV → `flags_o[1]` = NX only.
- `flush_i` pulse with `cnt_q` = 3 and a lock active → no issue or response in that cycle; next cycle `cnt_q` = 0, `busy_o` = 0, and `prio_q` is unchanged.
- Simultaneous issue and response at `cnt_q` = 2 → `cnt_q` stays 2; an assertion checks the counter never reaches `MaxInflight`+1.
